// File: rtl/dircc_counter_send_handler.sv
// Send side of the counter processing element: when the device state carries a pending
// rts flag, lock the state store, emit one counter packet per output edge, then clear rts.
module dircc_counter_send_handler #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 96,
  parameter int MAX_FANOUT = 4,
  parameter int USER_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            dev_addr,
  input  logic [2:0]                   fanout_count,
  input  logic [MAX_FANOUT*ADDR_W-1:0] fanout_addr,
  input  logic [USER_W-1:0]            read_user_state,
  output logic                         lock_req,
  input  logic                         lock_gnt,
  output logic [USER_W-1:0]            write_user_state,
  output logic                         write_state_valid,
  output logic [ADDR_W-1:0]            packet_out_dest,
  output logic [DATA_W-1:0]            packet_out_data,
  output logic                         packet_out_valid,
  input  logic                         packet_out_ready,
  output logic                         busy,
  output logic [15:0]                  packets_sent
);

  localparam int HALF_W = USER_W / 2;
  localparam int SEL_W  = (MAX_FANOUT > 1) ? $clog2(MAX_FANOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    SEND  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t            state_reg;
  logic [2:0]        idx_reg;
  logic [HALF_W-1:0] snapshot_reg;

  logic [ADDR_W-1:0] edge_addr [MAX_FANOUT];
  logic [2:0]        fanout_clamped;
  logic [2:0]        idx_next;
  logic              last_edge;
  logic [HALF_W-1:0] cur_count;
  logic [HALF_W-1:0] cur_rts;
  logic [USER_W-1:0] cleared_state;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_FANOUT; gi++) begin : g_edge
      assign edge_addr[gi] = fanout_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  assign cur_count     = read_user_state[USER_W-1:HALF_W];
  assign cur_rts       = read_user_state[HALF_W-1:0];
  assign cleared_state = {cur_count, {HALF_W{1'b0}}};

  always_comb begin
    fanout_clamped = fanout_count;
    if (int'(fanout_count) > MAX_FANOUT) fanout_clamped = 3'(MAX_FANOUT);
  end

  assign idx_next  = idx_reg + 3'd1;
  assign last_edge = (idx_reg == (fanout_clamped - 3'd1));

  // Payload: source address in the top field, count zero-extended into the low 64 bits.
  function automatic logic [DATA_W-1:0] pack_data(input logic [ADDR_W-1:0] src,
                                                  input logic [HALF_W-1:0] cnt);
    logic [DATA_W-1:0] d;
    d = '0;
    d[DATA_W-1 -: ADDR_W] = src;
    d[HALF_W-1:0]         = cnt;
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      idx_reg           <= '0;
      snapshot_reg      <= '0;
      lock_req          <= 1'b0;
      write_user_state  <= '0;
      write_state_valid <= 1'b0;
      packet_out_dest   <= '0;
      packet_out_data   <= '0;
      packet_out_valid  <= 1'b0;
      busy              <= 1'b0;
      packets_sent      <= '0;
    end else begin
      write_state_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cur_rts != '0) begin
            state_reg <= LOCK;
            lock_req  <= 1'b1;
            busy      <= 1'b1;
          end
        end

        LOCK: begin
          if (lock_gnt) begin
            snapshot_reg <= cur_count;
            idx_reg      <= '0;
            if (fanout_clamped == 3'd0) begin
              state_reg         <= CLEAR;
              write_user_state  <= cleared_state;
              write_state_valid <= 1'b1;
            end else begin
              state_reg        <= SEND;
              packet_out_valid <= 1'b1;
              packet_out_dest  <= edge_addr[0];
              packet_out_data  <= pack_data(dev_addr, cur_count);
            end
          end
        end

        SEND: begin
          // Outputs only move on an accept, so they hold steady through a stall.
          if (packet_out_valid && packet_out_ready) begin
            packets_sent <= packets_sent + 16'd1;
            if (last_edge) begin
              state_reg         <= CLEAR;
              packet_out_valid  <= 1'b0;
              write_user_state  <= cleared_state;
              write_state_valid <= 1'b1;
            end else begin
              idx_reg         <= idx_next;
              packet_out_dest <= edge_addr[idx_next[SEL_W-1:0]];
              packet_out_data <= pack_data(dev_addr, snapshot_reg);
            end
          end
        end

        CLEAR: begin
          state_reg <= IDLE;
          lock_req  <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state_reg        <= IDLE;
          lock_req         <= 1'b0;
          packet_out_valid <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dircc_counter_send_handler.sv
// Scoreboard bench for the counter send handler: packets and write-backs are queued as
// expected when each send is set up and popped as the DUT produces them.
module tb_dircc_counter_send_handler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dev_addr;
  logic [2:0]  fanout_count;
  logic [63:0] fanout_addr;
  logic [31:0] read_user_state;
  logic        lock_req;
  logic        lock_gnt = 1'b0;
  logic [31:0] write_user_state;
  logic        write_state_valid;
  logic [15:0] packet_out_dest;
  logic [95:0] packet_out_data;
  logic        packet_out_valid;
  logic        packet_out_ready;
  logic        busy;
  logic [15:0] packets_sent;

  always #5 clk = ~clk;

  dircc_counter_send_handler dut (
    .clk               (clk),
    .reset             (reset),
    .dev_addr          (dev_addr),
    .fanout_count      (fanout_count),
    .fanout_addr       (fanout_addr),
    .read_user_state   (read_user_state),
    .lock_req          (lock_req),
    .lock_gnt          (lock_gnt),
    .write_user_state  (write_user_state),
    .write_state_valid (write_state_valid),
    .packet_out_dest   (packet_out_dest),
    .packet_out_data   (packet_out_data),
    .packet_out_valid  (packet_out_valid),
    .packet_out_ready  (packet_out_ready),
    .busy              (busy),
    .packets_sent      (packets_sent)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // State store and arbiter models
  logic [31:0] user_state = '0;
  logic        load_req = 1'b0;
  logic [31:0] load_val = '0;
  assign read_user_state = user_state;

  always @(posedge clk) begin
    if (load_req) user_state <= load_val;
    else if (write_state_valid) user_state <= write_user_state;
  end

  always @(posedge clk) lock_gnt <= reset ? 1'b0 : lock_req;

  logic [15:0] addr_tab [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  function automatic logic [95:0] pack_exp(input logic [15:0] c);
    return {dev_addr, 16'h0000, 48'h0, c};
  endfunction

  typedef struct packed {
    logic [15:0] dest;
    logic [95:0] data;
  } pkt_t;

  pkt_t        pkt_q [$];
  logic [31:0] wr_q [$];
  pkt_t        mon_pkt;
  logic [31:0] mon_wr;
  int cyc = 0;
  int pkts_seen = 0;
  int wr_seen = 0;
  int gnt_cyc = 0;
  int wr_cyc = 0;
  int run_id = 0;
  int gnt_run = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (lock_gnt && gnt_run != run_id) begin
        gnt_run = run_id;
        gnt_cyc = cyc;
      end
      if (packet_out_valid && packet_out_ready) begin
        if (pkt_q.size() == 0) begin
          check_eq("unexpected_pkt", packet_out_dest, 16'h0);
        end else begin
          mon_pkt = pkt_q.pop_front();
          check_eq("pkt_dest", packet_out_dest, mon_pkt.dest);
          check_eq("pkt_data", packet_out_data, mon_pkt.data);
        end
        $display("cycle %0d: packet dest=%0h data=%0h", cyc, packet_out_dest, packet_out_data);
        pkts_seen++;
      end
      if (write_state_valid) begin
        if (wr_q.size() == 0) begin
          check_eq("unexpected_write", 1, 0);
        end else begin
          mon_wr = wr_q.pop_front();
          check_eq("write_data", write_user_state, mon_wr);
        end
        $display("cycle %0d: write user_state=%0h", cyc, write_user_state);
        wr_seen++;
        wr_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sent_model = '0;

  task automatic run_send(input logic [15:0] cnt, input int fo, input int stall_edge,
                          input int stall_n);
    int   npk;
    int   stall_cnt;
    int   exp_stall;
    int   p0;
    int   w0;
    bit   done;
    pkt_t tmp;
    npk       = (fo > 4) ? 4 : fo;
    stall_cnt = 0;
    exp_stall = (stall_edge >= 0 && stall_edge < npk) ? stall_n : 0;
    p0        = pkts_seen;
    w0        = wr_seen;
    done      = 1'b0;
    run_id++;
    for (int k = 0; k < npk; k++) begin
      tmp.dest = addr_tab[k];
      tmp.data = pack_exp(cnt);
      pkt_q.push_back(tmp);
    end
    wr_q.push_back({cnt, 16'h0000});
    fanout_count     = 3'(fo);
    packet_out_ready = 1'b1;
    load_val         = {cnt, 16'h0001};
    load_req         = 1'b1;
    step();
    load_req = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      if (packet_out_valid && stall_edge >= 0 && packet_out_dest == addr_tab[stall_edge]
          && stall_cnt < stall_n) begin
        packet_out_ready = 1'b0;
        stall_cnt++;
        check_eq("stall_data", packet_out_data, pack_exp(cnt));
      end else begin
        packet_out_ready = 1'b1;
      end
      if (wr_seen == w0 + 1 && !busy) done = 1'b1;
    end
    check_eq("send_done", done, 1'b1);
    sent_model = sent_model + 16'(npk);
    check_eq("pkt_count", pkts_seen - p0, npk);
    check_eq("write_count", wr_seen - w0, 1);
    check_eq("write_latency", wr_cyc - gnt_cyc, 1 + npk + exp_stall);
    check_eq("packets_sent", packets_sent, sent_model);
    check_eq("rts_cleared", user_state[15:0], 16'h0);
    check_eq("count_kept", user_state[31:16], cnt);
    check_eq("pkt_q_empty", pkt_q.size(), 0);
    repeat (3) step();
    check_eq("no_rearm", lock_req, 1'b0);
    $display("run cnt=%0h fanout=%0d stall=%0d: packets=%0d", cnt, fo, stall_n, pkts_seen - p0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int w0;
    dev_addr         = 16'hABCD;
    fanout_addr      = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    fanout_count     = 3'd0;
    packet_out_ready = 1'b0;
    reset            = 1'b1;
    repeat (3) step();
    check_eq("rst_lock_req", lock_req, 1'b0);
    check_eq("rst_valid", packet_out_valid, 1'b0);
    check_eq("rst_wsv", write_state_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sent", packets_sent, 16'h0);
    check_eq("rst_dest", packet_out_dest, 16'h0);
    check_eq("rst_data", packet_out_data, 96'h0);
    check_eq("rst_wdata", write_user_state, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("idle_lock_req", lock_req, 1'b0);
      check_eq("idle_valid", packet_out_valid, 1'b0);
      check_eq("idle_wsv", write_state_valid, 1'b0);
    end
    check_eq("idle_sent", packets_sent, 16'h0);

    run_send(16'h0005, 3, -1, 0);
    run_send(16'h0005, 3, 1, 4);
    run_send(16'h0009, 0, -1, 0);
    run_send(16'h0007, 7, -1, 0);

    // Preload the counter just below wrap, then send two packets
    step();
    force dut.packets_sent = 16'hFFFF;
    #1;
    release dut.packets_sent;
    check_eq("preload", packets_sent, 16'hFFFF);
    sent_model = 16'hFFFF;
    run_send(16'h0003, 2, -1, 0);
    check_eq("wrap_sent", packets_sent, 16'h0001);

    // Reset in the middle of a send, right after the first accept
    begin
      pkt_t tmp;
      tmp.dest = addr_tab[0];
      tmp.data = pack_exp(16'h000B);
      pkt_q.push_back(tmp);
    end
    run_id++;
    p0               = pkts_seen;
    w0               = wr_seen;
    fanout_count     = 3'd3;
    packet_out_ready = 1'b1;
    load_val         = {16'h000B, 16'h0001};
    load_req         = 1'b1;
    step();
    load_req = 1'b0;
    for (int c = 0; c < 50 && pkts_seen == p0; c++) step();
    check_eq("midrst_first_accept", pkts_seen - p0, 1);
    reset            = 1'b1;
    packet_out_ready = 1'b0;
    load_val         = 32'h0;
    load_req         = 1'b1;
    step();
    check_eq("midrst_valid", packet_out_valid, 1'b0);
    check_eq("midrst_lock_req", lock_req, 1'b0);
    check_eq("midrst_wsv", write_state_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_sent", packets_sent, 16'h0);
    reset    = 1'b0;
    load_req = 1'b0;
    repeat (5) step();
    check_eq("midrst_no_write", wr_seen - w0, 0);
    check_eq("midrst_sent_after", packets_sent, 16'h0);
    check_eq("midrst_q_empty", pkt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
